// File: rtl/paralelo_serial_phy_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : paralelo_serial_phy_tx_pkg
// Brief    : Shared constants and state encoding for the serial TX PHY.
// Revision : 1.0
// ============================================================================
package paralelo_serial_phy_tx_pkg;

  localparam logic [7:0] c_comma     = 8'hBC;
  localparam int         c_bit_cnt_w = 3;

  typedef enum logic [0:0] {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage : paralelo_serial_phy_tx_pkg
`default_nettype wire

// File: rtl/paralelo_serial_phy_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_phy
// Brief    : Single-clock FIFO with combinational head output.
// Revision : 1.0
// ============================================================================
module sync_fifo_phy #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_32f,
  input  logic             default_values,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_cw-1:0]  r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == c_cw'(DEPTH));
  assign empty     = (r_count == '0);
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_32f) begin
    if (default_values) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      r_count <= r_count + c_cw'(w_do_push) - c_cw'(w_do_pop);
    end
  end

  always_ff @(posedge clk_32f) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule : sync_fifo_phy
`default_nettype wire

// File: rtl/paralelo_serial_phy_tx.sv
`default_nettype none
// ============================================================================
// Module   : paralelo_serial_phy_tx
// Brief    : Byte-to-serial TX PHY; MSB-first 8-bit slots, comma fill/align.
// Revision : 1.0
// ============================================================================
module paralelo_serial_phy_tx
  import paralelo_serial_phy_tx_pkg::*;
#(
  parameter logic [7:0] COMMA      = c_comma,
  parameter int         BC_MIN     = 4,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk_32f,
  input  logic       default_values,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       data_out,
  output logic       active,
  output logic       sending_data
);

  localparam int c_ccw = $clog2(BC_MIN + 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_ccw-1:0]       r_comma_cnt;
  logic [c_ccw-1:0]       w_comma_cnt_nxt;
  logic [c_bit_cnt_w-1:0] r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_slot_is_data;
  logic                   r_data_out;
  logic                   r_sending;

  logic       w_boundary;
  logic       w_push;
  logic       w_pop;
  logic [7:0] w_fifo_head;
  logic       w_full;
  logic       w_empty;

  assign w_boundary   = &r_bit_cnt;
  assign w_push       = in_valid && !w_full;
  assign w_pop        = w_boundary && (r_state == ST_ACTIVE) && !w_empty;
  assign in_ready     = !w_full;
  assign data_out     = r_data_out;
  assign active       = (r_state == ST_ACTIVE);
  assign sending_data = r_sending;

  sync_fifo_phy #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_32f        (clk_32f),
    .default_values (default_values),
    .push           (w_push),
    .pop            (w_pop),
    .din            (in_data),
    .dout           (w_fifo_head),
    .full           (w_full),
    .empty          (w_empty)
  );

  always_ff @(posedge clk_32f) begin
    if (default_values) begin
      r_state     <= ST_SYNC;
      r_comma_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_comma_cnt <= w_comma_cnt_nxt;
    end
  end

  // In SYNC every slot load is a comma, so counting loads counts commas.
  always_comb begin
    w_state_nxt     = r_state;
    w_comma_cnt_nxt = r_comma_cnt;
    if (w_boundary && (r_state == ST_SYNC)) begin
      w_comma_cnt_nxt = r_comma_cnt + c_ccw'(1);
      if (w_comma_cnt_nxt == c_ccw'(BC_MIN)) w_state_nxt = ST_ACTIVE;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (default_values) begin
      r_bit_cnt      <= '0;
      r_shift        <= COMMA;
      r_slot_is_data <= 1'b0;
      r_data_out     <= 1'b0;
      r_sending      <= 1'b0;
    end else begin
      r_data_out <= r_shift[7];
      r_bit_cnt  <= r_bit_cnt + c_bit_cnt_w'(1);
      if (w_boundary) begin
        r_shift        <= w_pop ? w_fifo_head : COMMA;
        r_slot_is_data <= w_pop;
      end else begin
        r_shift <= {r_shift[6:0], 1'b0};
      end
      // Flag follows the slot: it flips with the MSB of the new symbol.
      if (r_bit_cnt == '0) r_sending <= r_slot_is_data;
    end
  end

endmodule : paralelo_serial_phy_tx
`default_nettype wire

// File: tb/tb_paralelo_serial_phy_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_paralelo_serial_phy_tx
// Brief    : Directed self-checking bench for the serial TX PHY.
// Revision : 1.0
// ============================================================================
module tb_paralelo_serial_phy_tx;

  logic       clk_32f = 1'b0;
  logic       default_values = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       data_out;
  logic       active;
  logic       sending_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] comma_v = 8'hBC;

  always #5 clk_32f = ~clk_32f;

  // Edges since reset release; after edge k data_out holds bit (k-1)%8 of slot (k-1)/8.
  always @(posedge clk_32f) begin
    if (default_values) cyc <= 0;
    else cyc <= cyc + 1;
  end

  paralelo_serial_phy_tx dut (
    .clk_32f        (clk_32f),
    .default_values (default_values),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .data_out       (data_out),
    .active         (active),
    .sending_data   (sending_data)
  );

  task automatic do_reset();
    @(negedge clk_32f);
    default_values = 1'b1;
    in_valid = 1'b0;
    @(negedge clk_32f);
    default_values = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc != n && g < 200) begin
      @(negedge clk_32f);
      g++;
    end
    checks++;
    if (cyc != n) begin
      errors++;
      $display("FAIL wait_cyc: got cyc=%0d required %0d", cyc, n);
    end
  endtask

  // Collect the next whole slot (starts on the negedge where cyc%8==1).
  task automatic get_slot(output logic [7:0] b, output logic sd, output logic stable);
    do @(negedge clk_32f); while ((cyc % 8) != 1);
    sd = sending_data;
    stable = 1'b1;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk_32f);
      b = {b[6:0], data_out};
      if (sending_data !== sd) stable = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [2:0] exp_v;
    do_reset();
    checks++;
    if ({data_out, active, sending_data, in_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_state: got {dout,act,sd,rdy}=%b required 0001",
               {data_out, active, sending_data, in_ready});
    end
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk_32f);
      exp_v = {comma_v[7 - ((k - 1) % 8)], (k >= 32), 1'b0};
      checks++;
      if ({data_out, active, sending_data} !== exp_v) begin
        errors++;
        $display("FAIL reset_stream cyc=%0d: got {dout,act,sd}=%b required %b",
                 k, {data_out, active, sending_data}, exp_v);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] b;
    logic sd, st;
    in_valid = 1'b1;
    in_data = 8'hA5;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: got %b required 1", in_ready);
    end
    @(negedge clk_32f);
    in_valid = 1'b0;
    get_slot(b, sd, st);
    checks++;
    if ({b, sd, st} !== {8'hA5, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL single_data: got byte=%h sd=%b stable=%b required a5 1 1", b, sd, st);
    end
    get_slot(b, sd, st);
    checks++;
    if ({b, sd, st} !== {8'hBC, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL single_after: got byte=%h sd=%b stable=%b required bc 0 1", b, sd, st);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vec [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    do_reset();
    fork
      begin : pusher
        for (int i = 0; i < 5; i++) begin
          int g = 0;
          in_valid = 1'b1;
          in_data = vec[i];
          if (i == 4) begin
            checks++;
            if (in_ready !== 1'b0) begin
              errors++;
              $display("FAIL b2b_full: got in_ready=%b required 0", in_ready);
            end
          end
          while (!in_ready && g < 100) begin
            @(negedge clk_32f);
            g++;
          end
          if (i == 4) begin
            checks++;
            if (cyc != 40 || in_ready !== 1'b1) begin
              errors++;
              $display("FAIL b2b_free: got ready at cyc=%0d rdy=%b required cyc 40 rdy 1", cyc, in_ready);
            end
          end
          @(negedge clk_32f);
        end
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_refull: got in_ready=%b required 0", in_ready);
        end
      end
      begin : capture
        logic [7:0] b, eb;
        logic sd, st;
        for (int j = 0; j < 11; j++) begin
          get_slot(b, sd, st);
          eb = (j >= 5 && j < 10) ? vec[j - 5] : 8'hBC;
          checks++;
          if ({b, sd, st} !== {eb, (j >= 5 && j < 10), 1'b1}) begin
            errors++;
            $display("FAIL b2b_slot%0d: got byte=%h sd=%b stable=%b required %h %b 1",
                     j, b, sd, st, eb, (j >= 5 && j < 10));
          end
        end
      end
    join
  endtask

  task automatic test_reset_mid_slot();
    logic [7:0] b;
    logic sd, st;
    do_reset();
    wait_cyc(32);
    in_valid = 1'b1; in_data = 8'h81; @(negedge clk_32f);
    in_data = 8'h42; @(negedge clk_32f);
    in_data = 8'h24; @(negedge clk_32f);
    in_valid = 1'b0;
    wait_cyc(44);
    checks++;
    if (sending_data !== 1'b1) begin
      errors++;
      $display("FAIL mid_in_data_slot: got sd=%b required 1", sending_data);
    end
    default_values = 1'b1;
    @(negedge clk_32f);
    checks++;
    if ({data_out, active, sending_data, in_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL mid_reset_state: got {dout,act,sd,rdy}=%b required 0001",
               {data_out, active, sending_data, in_ready});
    end
    default_values = 1'b0;
    for (int j = 0; j < 6; j++) begin
      get_slot(b, sd, st);
      checks++;
      if ({b, sd, st, active} !== {8'hBC, 1'b0, 1'b1, (j >= 3)}) begin
        errors++;
        $display("FAIL mid_slot%0d: got byte=%h sd=%b stable=%b act=%b required bc 0 1 %b",
                 j, b, sd, st, active, (j >= 3));
      end
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] b, eb;
    logic sd, st;
    do_reset();
    wait_cyc(33);
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 8'(i);
      @(negedge clk_32f);
    end
    in_data = 8'h05;
    for (int k = 37; k <= 41; k++) begin
      checks++;
      if (cyc != k || in_ready !== (k == 40)) begin
        errors++;
        $display("FAIL full_pop_ready cyc=%0d: got rdy=%b required %b", cyc, in_ready, (k == 40));
      end
      if (k < 41) @(negedge clk_32f);
    end
    in_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      get_slot(b, sd, st);
      eb = (j < 4) ? 8'(j + 2) : 8'hBC;
      checks++;
      if ({b, sd, st} !== {eb, (j < 4), 1'b1}) begin
        errors++;
        $display("FAIL full_pop_slot%0d: got byte=%h sd=%b stable=%b required %h %b 1",
                 j, b, sd, st, eb, (j < 4));
      end
    end
  endtask

  task automatic test_loopback();
    logic [7:0] exp_q [100];
    for (int i = 0; i < 100; i++) begin
      exp_q[i] = 8'($urandom_range(0, 255));
      if (exp_q[i] == 8'hBC) exp_q[i] = 8'h3C;
    end
    fork
      begin : pusher
        for (int i = 0; i < 100; i++) begin
          int g = 0;
          in_valid = 1'b1;
          in_data = exp_q[i];
          while (!in_ready && g < 100) begin
            @(negedge clk_32f);
            g++;
          end
          @(negedge clk_32f);
          in_valid = 1'b0;
          repeat ($urandom_range(0, 2)) @(negedge clk_32f);
        end
        in_valid = 1'b0;
      end
      begin : capture
        logic [7:0] b;
        logic sd, st;
        int got = 0;
        int s = 0;
        while (got < 100 && s < 300) begin
          get_slot(b, sd, st);
          s++;
          checks++;
          if (sd === 1'b1 && st === 1'b1) begin
            if (b !== exp_q[got]) begin
              errors++;
              $display("FAIL loop_byte%0d: got %h required %h", got, b, exp_q[got]);
            end
            got++;
          end else if (b !== 8'hBC || st !== 1'b1) begin
            errors++;
            $display("FAIL loop_idle: got byte=%h stable=%b required bc 1", b, st);
          end
        end
        checks++;
        if (got != 100) begin
          errors++;
          $display("FAIL loop_count: got %0d bytes required 100", got);
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid_slot();
    test_full_pop();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule : tb_paralelo_serial_phy_tx
`default_nettype wire
